// File: rtl/cache_mshr_fill_ctrl_if.sv
// Signal bundle between the MSHR fill controller and its neighbours:
// MSHR head, cache bank (victim read / fill write) and the memory request port.
interface cache_mshr_fill_ctrl_if #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int UUID_W      = 8
);
    // MSHR head entry
    logic                            mshr_valid;
    logic [UUID_W-1:0]               mshr_uuid;
    logic [ADDR_W-1:0]               mshr_block_addr;
    logic [BLOCK_WORDS-1:0]          mshr_write_status;
    logic [BLOCK_WORDS*WORD_W-1:0]   mshr_write_block;
    logic                            bank_empty;

    // Cache bank victim view and fill port
    logic                            victim_dirty;
    logic [ADDR_W-1:0]               victim_addr;
    logic [BLOCK_WORDS*WORD_W-1:0]   victim_block;
    logic                            fill_valid;
    logic                            fill_ready;
    logic [ADDR_W-1:0]               fill_addr;
    logic [BLOCK_WORDS*WORD_W-1:0]   fill_block;
    logic                            fill_dirty;

    // Memory request / response port
    logic                            mem_req_valid;
    logic                            mem_req_ready;
    logic                            mem_req_rw;
    logic [ADDR_W-1:0]               mem_req_addr;
    logic [WORD_W-1:0]               mem_req_data;
    logic                            mem_resp_valid;
    logic [WORD_W-1:0]               mem_resp_data;

    // Completion
    logic                            done_valid;
    logic [UUID_W-1:0]               done_uuid;

    modport master (
        input  mshr_valid, mshr_uuid, mshr_block_addr, mshr_write_status, mshr_write_block,
        output bank_empty,
        input  victim_dirty, victim_addr, victim_block,
        output fill_valid, fill_addr, fill_block, fill_dirty,
        input  fill_ready,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output done_valid, done_uuid
    );

    modport slave (
        output mshr_valid, mshr_uuid, mshr_block_addr, mshr_write_status, mshr_write_block,
        input  bank_empty,
        output victim_dirty, victim_addr, victim_block,
        input  fill_valid, fill_addr, fill_block, fill_dirty,
        output fill_ready,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  done_valid, done_uuid
    );
endinterface

// File: rtl/cache_mshr_fill_ctrl.sv
// Services the MSHR head miss: optional dirty-victim writeback, word-by-word block
// read, store-word merge, bank fill and head pop. One miss in flight at a time.
module cache_mshr_fill_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int UUID_W      = 8
) (
    input logic                    CLK,
    input logic                    nRST,
    cache_mshr_fill_ctrl_if.master bus
);
    localparam int                BEAT_W     = $clog2(BLOCK_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(WORD_W / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_RD_REQ,
        S_RD_DATA,
        S_FILL,
        S_POP
    } state_e;

    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] block_t;

    state_e                 state_q,        state_d;
    logic [BEAT_W-1:0]      beat_q,         beat_d;
    logic [UUID_W-1:0]      uuid_q,         uuid_d;
    logic [ADDR_W-1:0]      block_addr_q,   block_addr_d;
    logic [BLOCK_WORDS-1:0] write_status_q, write_status_d;
    block_t                 write_block_q,  write_block_d;
    logic [ADDR_W-1:0]      victim_addr_q,  victim_addr_d;
    block_t                 victim_block_q, victim_block_d;
    block_t                 fill_q,         fill_d;

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
        state_d        = state_q;
        beat_d         = beat_q;
        uuid_d         = uuid_q;
        block_addr_d   = block_addr_q;
        write_status_d = write_status_q;
        write_block_d  = write_block_q;
        victim_addr_d  = victim_addr_q;
        victim_block_d = victim_block_q;
        fill_d         = fill_q;

        case (state_q)
            S_IDLE: begin
                if (bus.mshr_valid) begin
                    uuid_d         = bus.mshr_uuid;
                    block_addr_d   = bus.mshr_block_addr;
                    write_status_d = bus.mshr_write_status;
                    write_block_d  = bus.mshr_write_block;
                    beat_d         = '0;
                    if (bus.victim_dirty) begin
                        victim_addr_d  = bus.victim_addr;
                        victim_block_d = bus.victim_block;
                        state_d        = S_WB;
                    end else begin
                        state_d        = S_RD_REQ;
                    end
                end
            end

            // mem_req_valid is constant-high here, so ready alone completes a beat.
            S_WB: begin
                if (bus.mem_req_ready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_RD_REQ;
                    end
                end
            end

            S_RD_REQ: begin
                if (bus.mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_RD_DATA;
                end
            end

            // Merge happens as each word lands, so fill_q is final on entry to FILL.
            S_RD_DATA: begin
                if (bus.mem_resp_valid) begin
                    fill_d[beat_q] = write_status_q[beat_q] ? write_block_q[beat_q]
                                                            : bus.mem_resp_data;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (bus.fill_ready) begin
                    state_d = S_POP;
                end
            end

            // The MSHR shifts during this cycle; its valid is not looked at until IDLE.
            S_POP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from state and latched data only.
    always_comb begin
        bus.bank_empty    = 1'b0;
        bus.done_valid    = 1'b0;
        bus.done_uuid     = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_req_data  = '0;
        bus.fill_valid    = 1'b0;
        bus.fill_addr     = '0;
        bus.fill_block    = '0;
        bus.fill_dirty    = 1'b0;

        case (state_q)
            S_WB: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_rw    = 1'b1;
                bus.mem_req_addr  = victim_addr_q + ADDR_W'(beat_q) * WORD_BYTES;
                bus.mem_req_data  = victim_block_q[beat_q];
            end
            S_RD_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_req_addr  = block_addr_q;
            end
            S_FILL: begin
                bus.fill_valid = 1'b1;
                bus.fill_addr  = block_addr_q;
                bus.fill_block = fill_q;
                bus.fill_dirty = |write_status_q;
            end
            S_POP: begin
                bus.bank_empty = 1'b1;
                bus.done_valid = 1'b1;
                bus.done_uuid  = uuid_q;
            end
            default: begin
            end
        endcase
    end

    // NOTE: the block-wide data registers are reset too, so an aborted miss leaves no stale words visible.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= S_IDLE;
            beat_q         <= '0;
            uuid_q         <= '0;
            block_addr_q   <= '0;
            write_status_q <= '0;
            write_block_q  <= '0;
            victim_addr_q  <= '0;
            victim_block_q <= '0;
            fill_q         <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q        <= state_d;
            beat_q         <= beat_d;
            uuid_q         <= uuid_d;
            block_addr_q   <= block_addr_d;
            write_status_q <= write_status_d;
            write_block_q  <= write_block_d;
            victim_addr_q  <= victim_addr_d;
            victim_block_q <= victim_block_d;
            fill_q         <= fill_d;
        end
    end
endmodule

// File: doc/cache_mshr_fill_ctrl.md
# cache_mshr_fill_ctrl

Sequences the head entry of the cache MSHR buffer through miss service. It optionally writes back a dirty victim, fetches the missing block from memory word by word, and merges buffered store words over the fill data. It then writes the merged block into the cache bank and pops the MSHR head by pulsing `bank_empty`. It sits between the MSHR buffer, the cache bank and the memory/DRAM request port, and owns exactly one outstanding miss at a time.

## Interface
- `ADDR_W`, 32: byte address width.
- `WORD_W`, 32: data word width; word stride in bytes = `WORD_W/8`.
- `BLOCK_WORDS`, 4: words per cache block (power of 2, ≥2).
- `UUID_W`, 8: request identifier width.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `mshr_valid`  in  1  MSHR head entry valid.
- `mshr_uuid`  in  UUID_W  head uuid.
- `mshr_block_addr`  in  ADDR_W  head block-aligned address.
- `mshr_write_status`  in  BLOCK_WORDS  per-word store-pending mask.
- `mshr_write_block`  in  BLOCK_WORDS*WORD_W  store data; word w at bits [w*WORD_W +: WORD_W].
- `bank_empty`  out  1  one-cycle pop pulse to MSHR buffer.
- `victim_dirty`  in  1  bank: victim way for the head index is valid and dirty (combinational).
- `victim_addr`  in  ADDR_W  victim block address.
- `victim_block`  in  BLOCK_WORDS*WORD_W  victim data.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_rw`  out  1  1 = write beat, 0 = block read.
- `mem_req_addr`  out  ADDR_W  request address.
- `mem_req_data`  out  WORD_W  write beat data.
- `mem_resp_valid`  in  1  read response beat valid.
- `mem_resp_data`  in  WORD_W  read response word.
- `fill_valid`  out  1  merged block ready for bank write.
- `fill_ready`  in  1  bank accepts fill.
- `fill_addr`  out  ADDR_W  fill block address.
- `fill_block`  out  BLOCK_WORDS*WORD_W  merged data.
- `fill_dirty`  out  1  OR-reduction of the latched write_status.
- `done_valid`  out  1  one-cycle miss-complete pulse.
- `done_uuid`  out  UUID_W  uuid of completed miss.

## Operation
- States: IDLE, WB, RD_REQ, RD_DATA, FILL, POP.
- IDLE, `mshr_valid`=1: latch uuid, block_addr, write_status and write_block. If `victim_dirty`=1, also latch victim_addr and victim_block and go to WB; otherwise go to RD_REQ. The head entry is stable while owned; merges only affect non-head entries.
- WB: issue BLOCK_WORDS write beats, `mem_req_rw`=1, addr = victim_addr + beat*(WORD_W/8), data = victim word[beat].
  - The beat counter advances only on `mem_req_valid && mem_req_ready`.
  - After the last beat, the counter wraps to 0 and the FSM goes to RD_REQ.
- RD_REQ: single request, `mem_req_rw`=0, addr = block_addr. On ready, clear the beat counter and go to RD_DATA.
- RD_DATA: each `mem_resp_valid` stores `mem_resp_data` into word[beat], in order from word 0. Beat count BLOCK_WORDS-1 accepted goes to FILL.
  - `mem_resp_valid` outside RD_DATA is ignored.
- Merge: fill word w = write_status[w] ? write_block[w] : response word w. This is registered, so it is stable throughout FILL.
- FILL: `fill_valid`=1 and is held with stable data until `fill_ready`; then go to POP.
- POP: `bank_empty`=1, `done_valid`=1, `done_uuid` = latched uuid for exactly one cycle; then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; no carry checks.

## Timing
- Reset: state IDLE. All outputs are 0: `bank_empty`, `mem_req_valid`, `mem_req_rw`, `mem_req_addr`, `mem_req_data`, `fill_valid`, `fill_addr`, `fill_block`, `fill_dirty`, `done_valid`, `done_uuid`. All latches and the beat counter are 0.
- All outputs are registered or decoded from state and latched data only; no combinational path from inputs to outputs.
- `mem_req_valid` remains high, with addr and data stable, until the ready handshake.
- Minimum latency, clean victim, ready always 1, responses back-to-back starting the cycle after the read request:
  - Accept at cycle 0, RD_REQ at cycle 1, data at cycles 2..(1+BLOCK_WORDS), FILL at cycle 2+BLOCK_WORDS, POP one cycle later.
  - With BLOCK_WORDS=4: `bank_empty` at cycle 7.
- A dirty victim adds BLOCK_WORDS cycles minimum.
- Gaps in `mem_resp_valid` stall the beat counter without loss.
- After POP, the FSM spends one IDLE cycle before accepting the next head. This lets the MSHR shift settle, so `mshr_valid` in POP is ignored.
- nRST asserted mid-miss: immediate return to the reset state. The in-flight miss is abandoned; no pop, no done.

## Test plan
- Clean read miss, block_addr 0x100, write_status=0, responses 0xA0..0xA3 -> one read req at 0x100, fill_block={0xA3,0xA2,0xA1,0xA0}, fill_dirty=0, `bank_empty` at cycle 7.
- Store merge, write_status=4'b0101, store words 0x11 (w0) and 0x33 (w2), responses 0xA0..0xA3 -> fill words {0xA3,0x33,0xA1,0x11}, fill_dirty=1.
- Dirty victim at 0x2000 -> four write beats to 0x2000, 0x2004, 0x2008, 0x200C carrying the victim words, before the read request.
- Backpressure: `mem_req_ready` low 3 cycles in WB and RD_REQ, `fill_ready` low 2 cycles, response gaps -> held stable signals, no duplicate beats, correct data.
- Back-to-back misses (uuid 5, then 6) -> done pulses carry 5 then 6, one `bank_empty` pulse each, at least one IDLE cycle between them.
- nRST pulsed during RD_DATA after 2 beats -> all outputs 0. The next miss completes normally with no stale words.
